// File: rtl/chan_pkg.sv
// Shared types and defaults for the channel join/responder block.
package chan_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int RESP_VAL_DEF = 42;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    GAP     = 2'd1,
    RESPOND = 2'd2
  } state_t;

endpackage

// File: rtl/chan_join_responder_if.sv
// Handshake bundle for the two input channels (A, B) and the response channel (C).
interface chan_join_responder_if
  import chan_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              a_valid;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  logic              c_valid;
  logic [DATA_W-1:0] c_data;
  logic              c_ready;

  modport slave (
    input  a_valid, a_data, b_valid, b_data, c_ready,
    output a_ready, b_ready, c_valid, c_data
  );

  modport master (
    output a_valid, a_data, b_valid, b_data, c_ready,
    input  a_ready, b_ready, c_valid, c_data
  );

endinterface

// File: rtl/chan_watchdog.sv
// Stall watchdog: counts consecutive stall cycles and raises a sticky alarm at TIMEOUT.
module chan_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  output logic deadlock
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT);

  logic [7:0] cnt_q, cnt_d;
  logic       deadlock_q, deadlock_d;

  // Counter saturates at the limit so a long stall cannot wrap it back to zero.
  always_comb begin
    cnt_d      = 8'd0;
    deadlock_d = deadlock_q;
    if (stall) begin
      cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + 8'd1;
    end
    if (cnt_d == LIMIT) begin
      deadlock_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= 8'd0;
      deadlock_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      deadlock_q <= deadlock_d;
    end
  end

  assign deadlock = deadlock_q;

endmodule

// File: rtl/chan_join_responder.sv
// Joins one transfer from each of channels A and B, then answers on C when the last flag is zero.
// Optional stall watchdog and deadlock port enabled by CHAN_JOIN_WATCHDOG_EN.
module chan_join_responder
  import chan_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int RESP_VAL = RESP_VAL_DEF,
  parameter int TIMEOUT  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  chan_join_responder_if.slave bus,
  output logic [DATA_W-1:0]    flag_q
`ifdef CHAN_JOIN_WATCHDOG_EN
  ,
  output logic                 deadlock
`endif
);

  localparam logic [DATA_W-1:0] RESP_WORD = DATA_W'(RESP_VAL);

  state_t            state_q, state_d;
  logic              a_done_q, a_done_d;
  logic              b_done_q, b_done_d;
  logic              a_ready_q, a_ready_d;
  logic              b_ready_q, b_ready_d;
  logic              c_valid_q, c_valid_d;
  logic [DATA_W-1:0] c_data_q, c_data_d;
  logic [DATA_W-1:0] flag_d;
  logic              a_xfer, b_xfer;

  // Readies are only ever high in COLLECT, so the transfer terms need no state qualifier.
  assign a_xfer = bus.a_valid & a_ready_q;
  assign b_xfer = bus.b_valid & b_ready_q;

  always_comb begin
    state_d  = state_q;
    a_done_d = a_done_q;
    b_done_d = b_done_q;
    flag_d   = flag_q;
    if (a_xfer) flag_d = bus.a_data;
    if (b_xfer) flag_d = bus.b_data;

    case (state_q)
      COLLECT: begin
        a_done_d = a_done_q | a_xfer;
        b_done_d = b_done_q | b_xfer;
        if (a_done_d && b_done_d) begin
          state_d  = GAP;
          a_done_d = 1'b0;
          b_done_d = 1'b0;
        end
      end
      GAP:     state_d = (flag_q == '0) ? RESPOND : COLLECT;
      RESPOND: if (bus.c_ready) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase

    // Outputs are derived from the next state so they are registered alongside it.
    a_ready_d = (state_d == COLLECT) && !a_done_d;
    b_ready_d = (state_d == COLLECT) && !b_done_d;
    c_valid_d = (state_d == RESPOND);
    c_data_d  = c_valid_d ? RESP_WORD : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= COLLECT;
      a_done_q  <= 1'b0;
      b_done_q  <= 1'b0;
      flag_q    <= '0;
      a_ready_q <= 1'b1;
      b_ready_q <= 1'b1;
      c_valid_q <= 1'b0;
      c_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      a_done_q  <= a_done_d;
      b_done_q  <= b_done_d;
      flag_q    <= flag_d;
      a_ready_q <= a_ready_d;
      b_ready_q <= b_ready_d;
      c_valid_q <= c_valid_d;
      c_data_q  <= c_data_d;
    end
  end

  assign bus.a_ready = a_ready_q;
  assign bus.b_ready = b_ready_q;
  assign bus.c_valid = c_valid_q;
  assign bus.c_data  = c_data_q;

`ifdef CHAN_JOIN_WATCHDOG_EN
  logic stall;

  // Stalled when one channel is joined and the other sender is idle, or when C is back-pressured.
  assign stall = ((state_q == COLLECT) &&
                  ((a_done_q && !b_done_q && !bus.b_valid) ||
                   (b_done_q && !a_done_q && !bus.a_valid))) ||
                 ((state_q == RESPOND) && !bus.c_ready);

  chan_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .stall   (stall),
    .deadlock(deadlock)
  );
`endif

endmodule

// File: tb/tb_chan_join_responder.sv
// Bench for chan_join_responder: directed scenarios plus random traffic against a round-level model.
module tb_chan_join_responder;
  import chan_pkg::*;

  localparam int DW = 8;
  localparam int RV = 42;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] flag_q;
`ifdef CHAN_JOIN_WATCHDOG_EN
  logic          deadlock;
`endif

  chan_join_responder_if #(.DATA_W(DW)) bus ();

  chan_join_responder #(
    .DATA_W  (DW),
    .RESP_VAL(RV),
    .TIMEOUT (TO)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
`ifdef CHAN_JOIN_WATCHDOG_EN
    .deadlock(deadlock),
`endif
    .flag_q(flag_q)
  );

  always #5 clk = ~clk;

  int nchecks = 0;
  int nerr    = 0;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    bus.a_data  = '0;
    bus.b_data  = '0;
    bus.c_ready = 1'b1;
  endtask

  task automatic do_reset;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    bus.a_valid = 1'b1; bus.a_data = 8'h11;
    bus.b_valid = 1'b1; bus.b_data = 8'h22;
    bus.c_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    idle();
    nchecks++;
    if ({bus.a_ready, bus.b_ready, bus.c_valid} !== 3'b110) begin
      nerr++; $display("FAIL reset_ctrl: got ar/br/cv=%b required 110", {bus.a_ready, bus.b_ready, bus.c_valid});
    end
    nchecks++;
    if ({flag_q, bus.c_data} !== 16'h0000) begin
      nerr++; $display("FAIL reset_data: got flag=%0d c_data=%0d required 0/0", flag_q, bus.c_data);
    end
`ifdef CHAN_JOIN_WATCHDOG_EN
    nchecks++;
    if (deadlock !== 1'b0) begin
      nerr++; $display("FAIL reset_deadlock: got %b required 0", deadlock);
    end
`endif
  endtask

  task automatic test_zero_pair;
    do_reset();
    bus.a_valid = 1'b1; bus.a_data = 8'd0;
    bus.b_valid = 1'b1; bus.b_data = 8'd0;
    tick();
    idle();
    nchecks++;
    if ({bus.a_ready, bus.b_ready, bus.c_valid} !== 3'b000) begin
      nerr++; $display("FAIL s1_gap: got ar/br/cv=%b required 000", {bus.a_ready, bus.b_ready, bus.c_valid});
    end
    tick();
    nchecks++;
    if ({bus.c_valid, bus.c_data} !== {1'b1, 8'd42}) begin
      nerr++; $display("FAIL s1_resp: got cv=%b c_data=%0d required 1/42", bus.c_valid, bus.c_data);
    end
    tick();
    nchecks++;
    if ({bus.c_valid, bus.c_data, bus.a_ready, bus.b_ready} !== {1'b0, 8'd0, 2'b11}) begin
      nerr++; $display("FAIL s1_after: got cv=%b c_data=%0d rdy=%b%b required 0/0/11", bus.c_valid, bus.c_data, bus.a_ready, bus.b_ready);
    end
  endtask

  task automatic test_staggered;
    do_reset();
    bus.a_valid = 1'b1; bus.a_data = 8'd5;
    tick();
    bus.a_valid = 1'b0;
    nchecks++;
    if ({bus.a_ready, bus.b_ready, flag_q} !== {2'b01, 8'd5}) begin
      nerr++; $display("FAIL s2_a_only: got rdy=%b%b flag=%0d required 01/5", bus.a_ready, bus.b_ready, flag_q);
    end
    tick(); tick(); tick();
    bus.b_valid = 1'b1; bus.b_data = 8'd3;
    tick();
    idle();
    nchecks++;
    if ({bus.a_ready, bus.b_ready, flag_q} !== {2'b00, 8'd3}) begin
      nerr++; $display("FAIL s2_gap: got rdy=%b%b flag=%0d required 00/3", bus.a_ready, bus.b_ready, flag_q);
    end
    tick();
    nchecks++;
    if ({bus.a_ready, bus.c_valid, flag_q} !== {2'b10, 8'd3}) begin
      nerr++; $display("FAIL s2_return: got ar=%b cv=%b flag=%0d required 1/0/3", bus.a_ready, bus.c_valid, flag_q);
    end
  endtask

  task automatic test_b_wins;
    do_reset();
    bus.a_valid = 1'b1; bus.a_data = 8'd7;
    bus.b_valid = 1'b1; bus.b_data = 8'd0;
    tick();
    idle();
    nchecks++;
    if (flag_q !== 8'd0) begin
      nerr++; $display("FAIL s3_flag: got %0d required 0", flag_q);
    end
    tick();
    nchecks++;
    if ({bus.c_valid, bus.c_data} !== {1'b1, 8'd42}) begin
      nerr++; $display("FAIL s3_resp: got cv=%b c_data=%0d required 1/42", bus.c_valid, bus.c_data);
    end
  endtask

  task automatic test_hold_off;
    do_reset();
    bus.a_valid = 1'b1; bus.a_data = 8'd4;
    tick();
    bus.a_data = 8'd9;
    for (int i = 0; i < 3; i++) begin
      nchecks++;
      if ({bus.a_ready, flag_q} !== {1'b0, 8'd4}) begin
        nerr++; $display("FAIL hold_a: got ar=%b flag=%0d required 0/4", bus.a_ready, flag_q);
      end
      tick();
    end
    bus.b_valid = 1'b1; bus.b_data = 8'd2;
    tick();
    bus.b_valid = 1'b0;
    tick();
    nchecks++;
    if ({bus.a_ready, flag_q} !== {1'b1, 8'd2}) begin
      nerr++; $display("FAIL hold_back: got ar=%b flag=%0d required 1/2", bus.a_ready, flag_q);
    end
    tick();
    nchecks++;
    if ({bus.a_ready, flag_q} !== {1'b0, 8'd9}) begin
      nerr++; $display("FAIL hold_kept: got ar=%b flag=%0d required 0/9", bus.a_ready, flag_q);
    end
    idle();
  endtask

  task automatic test_back_to_back;
    do_reset();
    bus.a_valid = 1'b1; bus.a_data = 8'd1;
    bus.b_valid = 1'b1;
    for (int r = 0; r < 4; r++) begin
      bus.b_data = 8'(r + 10);
      nchecks++;
      if ({bus.a_ready, bus.b_ready} !== 2'b11) begin
        nerr++; $display("FAIL b2b_collect%0d: got rdy=%b%b required 11", r, bus.a_ready, bus.b_ready);
      end
      tick();
      nchecks++;
      if ({bus.a_ready, bus.b_ready, flag_q} !== {2'b00, 8'(r + 10)}) begin
        nerr++; $display("FAIL b2b_gap%0d: got rdy=%b%b flag=%0d required 00/%0d", r, bus.a_ready, bus.b_ready, flag_q, r + 10);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_resp_stall;
    do_reset();
    bus.a_valid = 1'b1; bus.b_valid = 1'b1;
    bus.c_ready = 1'b0;
    tick();
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      nchecks++;
      if ({bus.c_valid, bus.c_data} !== {1'b1, 8'd42}) begin
        nerr++; $display("FAIL s5_hold%0d: got cv=%b c_data=%0d required 1/42", i, bus.c_valid, bus.c_data);
      end
      tick();
    end
    bus.c_ready = 1'b1;
    nchecks++;
    if ({bus.c_valid, bus.c_data} !== {1'b1, 8'd42}) begin
      nerr++; $display("FAIL s5_last: got cv=%b c_data=%0d required 1/42", bus.c_valid, bus.c_data);
    end
    tick();
    nchecks++;
    if ({bus.c_valid, bus.c_data, bus.a_ready} !== {1'b0, 8'd0, 1'b1}) begin
      nerr++; $display("FAIL s5_done: got cv=%b c_data=%0d ar=%b required 0/0/1", bus.c_valid, bus.c_data, bus.a_ready);
    end
`ifdef CHAN_JOIN_WATCHDOG_EN
    nchecks++;
    if (deadlock !== 1'b0) begin
      nerr++; $display("FAIL s5_deadlock: got %b required 0", deadlock);
    end
`endif
  endtask

  task automatic test_reset_in_gap;
    do_reset();
    bus.a_valid = 1'b1; bus.a_data = 8'd0;
    bus.b_valid = 1'b1; bus.b_data = 8'd0;
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nchecks++;
    if ({bus.a_ready, bus.b_ready, bus.c_valid, flag_q} !== {3'b110, 8'd0}) begin
      nerr++; $display("FAIL s6_reset: got rdy=%b%b cv=%b flag=%0d required 11/0/0", bus.a_ready, bus.b_ready, bus.c_valid, flag_q);
    end
    tick();
    nchecks++;
    if ({bus.a_ready, bus.b_ready, bus.c_valid} !== 3'b110) begin
      nerr++; $display("FAIL s6_no_resp: got rdy=%b%b cv=%b required 11/0", bus.a_ready, bus.b_ready, bus.c_valid);
    end
  endtask

`ifdef CHAN_JOIN_WATCHDOG_EN
  task automatic test_watchdog;
    do_reset();
    bus.a_valid = 1'b1; bus.a_data = 8'd6;
    tick();
    bus.a_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      nchecks++;
      if (deadlock !== (i >= TO)) begin
        nerr++; $display("FAIL wd_cycle%0d: got deadlock=%b required %b", i, deadlock, (i >= TO));
      end
    end
    bus.b_valid = 1'b1;
    tick();
    idle();
    tick(); tick();
    nchecks++;
    if ({deadlock, bus.a_ready} !== 2'b11) begin
      nerr++; $display("FAIL wd_sticky: got deadlock=%b ar=%b required 1/1", deadlock, bus.a_ready);
    end
  endtask
`endif

  // Round-level model: which channels have joined, whether the gap or a response is pending.
  task automatic test_random;
    bit      m_a_got, m_b_got, m_gap, m_resp;
    bit      ax, bx, stall;
    int      m_flag, m_stall_cnt;
    bit      m_dl;
    bit      av, bv, cr;
    int      ad, bd;
    do_reset();
    m_a_got = 0; m_b_got = 0; m_gap = 0; m_resp = 0;
    m_flag = 0; m_stall_cnt = 0; m_dl = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      nchecks++;
      if ({bus.a_ready, bus.b_ready, bus.c_valid} !==
          {!m_gap && !m_resp && !m_a_got, !m_gap && !m_resp && !m_b_got, m_resp}) begin
        nerr++; $display("FAIL rnd_ctrl@%0d: got ar/br/cv=%b%b%b required %b%b%b", cyc,
                         bus.a_ready, bus.b_ready, bus.c_valid,
                         !m_gap && !m_resp && !m_a_got, !m_gap && !m_resp && !m_b_got, m_resp);
      end
      nchecks++;
      if ({bus.c_data, flag_q} !== {8'(m_resp ? RV : 0), 8'(m_flag)}) begin
        nerr++; $display("FAIL rnd_data@%0d: got c_data=%0d flag=%0d required %0d/%0d", cyc,
                         bus.c_data, flag_q, m_resp ? RV : 0, m_flag);
      end
`ifdef CHAN_JOIN_WATCHDOG_EN
      nchecks++;
      if (deadlock !== m_dl) begin
        nerr++; $display("FAIL rnd_deadlock@%0d: got %b required %b", cyc, deadlock, m_dl);
      end
`endif
      av = ($urandom_range(0, 9) < 6);
      bv = ($urandom_range(0, 9) < 5);
      cr = ($urandom_range(0, 9) < 5);
      ad = $urandom_range(0, 3);
      bd = $urandom_range(0, 3);
      bus.a_valid = av; bus.a_data = 8'(ad);
      bus.b_valid = bv; bus.b_data = 8'(bd);
      bus.c_ready = cr;

      stall = (!m_gap && !m_resp && (m_a_got != m_b_got) && (m_a_got ? !bv : !av)) ||
              (m_resp && !cr);
      m_stall_cnt = stall ? m_stall_cnt + 1 : 0;
      if (m_stall_cnt >= TO) m_dl = 1;

      if (m_resp) begin
        if (cr) m_resp = 0;
      end else if (m_gap) begin
        m_gap  = 0;
        m_resp = (m_flag == 0);
      end else begin
        ax = av && !m_a_got;
        bx = bv && !m_b_got;
        if (ax) m_flag = ad;
        if (bx) m_flag = bd;
        m_a_got = m_a_got || ax;
        m_b_got = m_b_got || bx;
        if (m_a_got && m_b_got) begin
          m_a_got = 0; m_b_got = 0; m_gap = 1;
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    @(negedge clk);
    test_reset();
    test_zero_pair();
    test_staggered();
    test_b_wins();
    test_hold_off();
    test_back_to_back();
    test_resp_stall();
    test_reset_in_gap();
`ifdef CHAN_JOIN_WATCHDOG_EN
    test_watchdog();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/chan_join_responder.md
CHAN_JOIN_RESPONDER -- requirements
Module: chan_join_responder

Interface
REQ-001 Parameter DATA_W, default 8, width of all channel data buses.
REQ-002 Parameter RESP_VAL, default 42, value sent on channel C when a response is due.
REQ-003 Parameter TIMEOUT, default 16, stall-cycle limit for the watchdog (range 2..255).
REQ-004 clk  in  1  single clock; all logic on posedge clk.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 a_valid  in  1  channel A sender offers data.
REQ-007 a_data  in  DATA_W  channel A payload.
REQ-008 a_ready  out  1  block accepts channel A.
REQ-009 b_valid / b_data / b_ready  in / in / out  1 / DATA_W / 1  channel B, same meaning as A.
REQ-010 c_valid  out  1  response offered on channel C.
REQ-011 c_data  out  DATA_W  response payload.
REQ-012 c_ready  in  1  downstream accepts C.
REQ-013 flag_q  out  DATA_W  last captured flag value.
REQ-014 deadlock  out  1  sticky watchdog alarm; present only with CHAN_JOIN_WATCHDOG_EN.

Function
REQ-015 A transfer occurs on a channel when valid and ready are both high at a rising edge.
REQ-016 The FSM SHALL have states COLLECT, GAP, RESPOND.
REQ-017 In COLLECT, a_ready SHALL be high until A has transferred once in this round; the same rule applies independently to b_ready.
REQ-018 Each transfer captures its data into flag_q; if A and B transfer in the same cycle, B's data wins.
REQ-019 In the cycle after both channels have transferred, the FSM SHALL enter GAP; A and B done-bits clear on that entry.
REQ-020 GAP lasts exactly one cycle, with a_ready = b_ready = 0.
REQ-021 After GAP: if flag_q == 0, enter RESPOND; otherwise return to COLLECT.
REQ-022 In RESPOND, c_valid = 1 and c_data = RESP_VAL; on c_ready, return to COLLECT the next cycle.
REQ-023 c_valid SHALL be 0 outside RESPOND; c_data SHALL be 0 when c_valid is 0.
REQ-024 Minimum round latency, with both inputs valid and c_ready high: capture in cycle 0, GAP in cycle 1, c_valid in cycle 2, COLLECT in cycle 3.
REQ-025 Channel data arriving while its done-bit is set SHALL be held off by ready = 0, never dropped or overwritten.

Reset
REQ-026 rst SHALL force: state = COLLECT, done-bits = 0, flag_q = 0, c_valid = 0, c_data = 0, watchdog count = 0, deadlock = 0.
REQ-027 Reset asserted mid-round SHALL abandon the round; any partially captured channel is lost.
REQ-028 After reset, a_ready and b_ready SHALL both be 1 in the first cycle.

Configuration
REQ-029 Macro CHAN_JOIN_WATCHDOG_EN, when defined, SHALL include a stall counter that increments each cycle spent in either of these conditions, and otherwise clears:
- in COLLECT with exactly one done-bit set and the other channel not valid;
- in RESPOND with c_ready = 0.
REQ-030 When the counter reaches TIMEOUT, deadlock SHALL be set and stay high until rst; the FSM continues operating.
REQ-031 When the macro is not defined, the counter and the deadlock port SHALL be absent and the function SHALL be otherwise identical.

Structure
REQ-032 The FSM state enum, DATA_W default and RESP_VAL default SHALL live in shared package chan_pkg.
REQ-033 The watchdog SHALL be a sub-module, chan_watchdog (inputs: clk, rst, stall; output: deadlock), instantiated only under CHAN_JOIN_WATCHDOG_EN.

Verification
REQ-034 Scenario 1: A = 0 and B = 0 valid together, c_ready = 1 -> c_valid high 2 cycles later with c_data = 42 for 1 cycle.
REQ-035 Scenario 2: A = 5 in cycle 0, B = 3 in cycle 4 -> flag_q = 3, no c_valid, and a_ready = 1 again 2 cycles after the B transfer.
REQ-036 Scenario 3: A = 7 and B = 0 in the same cycle -> flag_q = 0 (B wins) and a response of 42 is issued.
REQ-037 Scenario 4 (watchdog on, TIMEOUT = 16): A transfers, B never valid -> deadlock rises exactly 16 cycles after the A transfer and stays high.
REQ-038 Scenario 5: RESPOND with c_ready held low for 10 cycles, then high -> c_data stable at 42 throughout, no deadlock.
REQ-039 Scenario 6: rst pulsed while in GAP -> next cycle state = COLLECT, flag_q = 0, c_valid = 0, both readies = 1.
